// File: rtl/trex_game_if.sv
// Signal bundle between the game controller and the downstream game blocks
// (trex character, obstacles, renderer).
//
// Handshake: frame_tick is the only strobe, and it has no ready. Consumers
// must take every tick. jump is only meaningful while frame_tick is high.
// game_rst is a standalone one-cycle pulse. timer, speed, score, crash and
// playing are levels that hold until the controller changes them.
interface trex_game_if;
    logic        btn_jump;
    logic        collide;
    logic        frame_tick;
    logic [5:0]  timer;
    logic [3:0]  speed;
    logic        jump;
    logic        crash;
    logic        game_rst;
    logic [16:0] score;
    logic        playing;

    // The controller drives the game-state outputs.
    modport master (
        input  btn_jump, collide,
        output frame_tick, timer, speed, jump, crash, game_rst, score, playing
    );

    // The game blocks and the input front-end.
    modport slave (
        output btn_jump, collide,
        input  frame_tick, timer, speed, jump, crash, game_rst, score, playing
    );
endinterface

// File: rtl/trex_game_ctrl.sv
// T-rex runner game sequencer. It provides the frame divider, the 0..59 frame
// timer, the speed ramp, frame-aligned jumps, crash latching with a button
// lockout, the score, and the restart pulse.
module trex_game_ctrl #(
    parameter int CLK_PER_FRAME   = 1_666_666,
    parameter int INIT_SPEED      = 6,
    parameter int MAX_SPEED       = 13,
    parameter int FRAMES_PER_STEP = 600,
    parameter int LOCKOUT_FRAMES  = 30,
    parameter int SCORE_MAX       = 99999
) (
    input  logic              clk,
    input  logic              rst,
    trex_game_if.master       bus,
    output logic [1:0]        state_dbg
);
    localparam int DIV_W  = (CLK_PER_FRAME > 1)   ? $clog2(CLK_PER_FRAME)   : 1;
    localparam int STEP_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int LOCK_W = (LOCKOUT_FRAMES > 0)  ? $clog2(LOCKOUT_FRAMES + 1) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_PER_FRAME - 1);
    localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(FRAMES_PER_STEP - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST  = LOCK_W'(LOCKOUT_FRAMES);
    localparam logic [3:0]        SPEED_INIT = 4'(INIT_SPEED);
    localparam logic [3:0]        SPEED_TOP  = 4'(MAX_SPEED);
    localparam logic [16:0]       SCORE_TOP  = 17'(SCORE_MAX);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PLAYING = 2'd1,
        S_CRASHED = 2'd2,
        S_LOCKOUT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_cnt;
    logic [STEP_W-1:0]  step_cnt;
    logic [LOCK_W-1:0]  lock_cnt;
    logic [5:0]         timer_q;
    logic [3:0]         speed_q;
    logic [16:0]        score_q;
    logic               btn_prev, pending, game_rst_q;
    logic               tick, press, jump_w, start, restart;

    assign tick  = (div_cnt == DIV_LAST);
    assign press = bus.btn_jump & ~btn_prev;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state, plus jump/start/restart decisions. A crash takes priority over a jump.
    always_comb begin
        state_d = state_q;
        jump_w  = 1'b0;
        start   = 1'b0;
        restart = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tick && (pending || press)) begin
                    jump_w  = 1'b1;
                    start   = 1'b1;
                    state_d = S_PLAYING;
                end
            end
            S_PLAYING: begin
                if (tick) begin
                    if (bus.collide)             state_d = S_CRASHED;
                    else if (pending || press)   jump_w  = 1'b1;
                end
            end
            S_CRASHED: state_d = S_LOCKOUT;
            S_LOCKOUT: begin
                if (lock_cnt == LOCK_LAST && press) begin
                    restart = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: divider, timer, button edge, pending jump, score/speed ramp and lockout count.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt    <= '0;
            step_cnt   <= '0;
            lock_cnt   <= '0;
            timer_q    <= '0;
            speed_q    <= SPEED_INIT;
            score_q    <= '0;
            btn_prev   <= 1'b0;
            pending    <= 1'b0;
            game_rst_q <= 1'b0;
        end else begin
            div_cnt    <= tick ? '0 : div_cnt + 1'b1;
            btn_prev   <= bus.btn_jump;
            game_rst_q <= restart;
            if (tick) timer_q <= (timer_q == 6'd59) ? 6'd0 : timer_q + 6'd1;

            // Only live play phases remember a press. Each tick consumes it.
            if (state_q == S_IDLE || state_q == S_PLAYING) begin
                if (tick)       pending <= 1'b0;
                else if (press) pending <= 1'b1;
            end

            if (state_q == S_PLAYING && tick && !bus.collide) begin
                if (score_q != SCORE_TOP) score_q <= score_q + 17'd1;
                if (step_cnt == STEP_LAST) begin
                    step_cnt <= '0;
                    if (speed_q != SPEED_TOP) speed_q <= speed_q + 4'd1;
                end else begin
                    step_cnt <= step_cnt + 1'b1;
                end
            end

            if (state_q == S_CRASHED)
                lock_cnt <= '0;
            else if (state_q == S_LOCKOUT && tick && lock_cnt != LOCK_LAST)
                lock_cnt <= lock_cnt + 1'b1;

            if (start || restart) begin
                score_q  <= '0;
                speed_q  <= SPEED_INIT;
                step_cnt <= '0;
            end
            if (restart) pending <= 1'b0;
        end
    end

    assign bus.frame_tick = tick;
    assign bus.timer      = timer_q;
    assign bus.speed      = speed_q;
    assign bus.score      = score_q;
    assign bus.jump       = jump_w;
    assign bus.game_rst   = game_rst_q;
    assign bus.crash      = (state_q == S_CRASHED) || (state_q == S_LOCKOUT);
    assign bus.playing    = (state_q == S_PLAYING);
    assign state_dbg      = state_q;
endmodule
